// File: rtl/uart_cmd_pkg.sv
// Shared types and byte constants for the UART command parser.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        HUNT_AA,
        HUNT_55,
        CMD,
        ADDR_HI,
        ADDR_LO,
        LEN,
        DATA
    } state_t;

    localparam logic [7:0] SYNC0     = 8'hAA;
    localparam logic [7:0] SYNC1     = 8'h55;
    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] RESP_ACK  = 8'h06;
    localparam logic [7:0] RESP_NAK  = 8'h15;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous payload FIFO with full/empty flags; push and pop may share a
// cycle even when full. Head entry reads as zero while empty.
module cmd_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers alone define validity, and
    // pop_data is masked while empty so stale contents never leak out.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Sync hunt, header decode and payload buffering between the host UART and
// the ROM write engine, with single-byte ACK/NAK responses.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 100000
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic [15:0] cmd_addr,
    output logic [8:0]  cmd_len,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [7:0]  wr_data,
    output logic [15:0] wr_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [7:0]  resp_data,
    output logic        error
);

    localparam int             TW          = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TIMEOUT_VAL = TW'(TIMEOUT);

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] timer;
    logic [7:0]    hdr_code;
    logic [15:0]   hdr_addr;
    logic [15:0]   cur_addr;
    logic [8:0]    remaining;
    logic [8:0]    len_val;
    logic          push, pop, ack, nak;
    logic          cap_code, cap_hi, cap_lo, hdr_done;
    logic          timeout_hit;
    logic          fifo_full, fifo_empty;
    logic [23:0]   fifo_out;

    assign len_val     = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
    assign wr_valid    = !fifo_empty;
    assign pop         = wr_valid && wr_ready;
    assign wr_addr     = fifo_out[23:8];
    assign wr_data     = fifo_out[7:0];
    assign timeout_hit = (state != HUNT_AA) && !rx_ready && (timer == TIMEOUT_VAL);

    // NOTE: non-blocking assignments for all registered state so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state <= HUNT_AA;
        else          state <= state_next;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        ack        = 1'b0;
        nak        = 1'b0;
        cap_code   = 1'b0;
        cap_hi     = 1'b0;
        cap_lo     = 1'b0;
        hdr_done   = 1'b0;
        if (timeout_hit) begin
            nak        = 1'b1;
            state_next = HUNT_AA;
        end else if (rx_ready) begin
            unique case (state)
                HUNT_AA: if (rx_data == SYNC0) state_next = HUNT_55;
                HUNT_55: begin
                    if (rx_data == SYNC1)      state_next = CMD;
                    else if (rx_data != SYNC0) state_next = HUNT_AA;
                end
                CMD: begin
                    if (rx_data == CMD_READ || rx_data == CMD_WRITE) begin
                        cap_code   = 1'b1;
                        state_next = ADDR_HI;
                    end else begin
                        nak        = 1'b1;
                        state_next = HUNT_AA;
                    end
                end
                ADDR_HI: begin
                    cap_hi     = 1'b1;
                    state_next = ADDR_LO;
                end
                ADDR_LO: begin
                    cap_lo     = 1'b1;
                    state_next = LEN;
                end
                LEN: begin
                    hdr_done = 1'b1;
                    if (hdr_code == CMD_READ) begin
                        ack        = 1'b1;
                        state_next = HUNT_AA;
                    end else begin
                        state_next = DATA;
                    end
                end
                DATA: begin
                    // A full FIFO only has room if the head leaves this same cycle.
                    if (fifo_full && !pop) begin
                        nak        = 1'b1;
                        state_next = HUNT_AA;
                    end else begin
                        push = 1'b1;
                        if (remaining == 9'd1) begin
                            ack        = 1'b1;
                            state_next = HUNT_AA;
                        end
                    end
                end
                default: state_next = HUNT_AA;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            timer <= '0;
        end else if (rx_ready || state == HUNT_AA) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cmd_valid  <= 1'b0;
            cmd_code   <= '0;
            cmd_addr   <= '0;
            cmd_len    <= '0;
            hdr_code   <= '0;
            hdr_addr   <= '0;
            cur_addr   <= '0;
            remaining  <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            error      <= 1'b0;
        end else begin
            cmd_valid <= hdr_done;
            error     <= nak;
            if (cap_code) hdr_code        <= rx_data;
            if (cap_hi)   hdr_addr[15:8]  <= rx_data;
            if (cap_lo)   hdr_addr[7:0]   <= rx_data;
            if (hdr_done) begin
                cmd_code  <= hdr_code;
                cmd_addr  <= hdr_addr;
                cmd_len   <= len_val;
                cur_addr  <= hdr_addr;
                remaining <= len_val;
            end
            if (push) begin
                cur_addr  <= cur_addr + 16'd1;
                remaining <= remaining - 9'd1;
            end
            // A fresh response overwrites a pending one.
            if (ack || nak) begin
                resp_valid <= 1'b1;
                resp_data  <= ack ? RESP_ACK : RESP_NAK;
            end else if (resp_valid && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (24)
    ) u_fifo (
        .clk       (clk),
        .n_reset   (n_reset),
        .push      (push),
        .push_data ({cur_addr, rx_data}),
        .pop       (pop),
        .pop_data  (fifo_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed scenarios plus random packets scored
// against a byte-scanning reference model.
module tb_uart_cmd_parser;

    localparam int FIFO_DEPTH = 16;
    localparam int TIMEOUT    = 200;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic [15:0] cmd_addr;
    logic [8:0]  cmd_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_data;
    logic [15:0] wr_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [7:0]  resp_data;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [32:0] cmd_obs[$];
    logic [23:0] wr_obs[$];
    logic [7:0]  resp_obs[$];
    int          err_obs;

    logic [32:0] exp_cmd[$];
    logic [23:0] exp_wr[$];
    logic [7:0]  exp_resp[$];
    int          exp_err;

    bit rand_wr = 1'b0;

    uart_cmd_parser #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .cmd_valid  (cmd_valid),
        .cmd_code   (cmd_code),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .wr_addr    (wr_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (n_reset) begin
            if (cmd_valid)              cmd_obs.push_back({cmd_code, cmd_addr, cmd_len});
            if (wr_valid && wr_ready)   wr_obs.push_back({wr_addr, wr_data});
            if (resp_valid && resp_ready) resp_obs.push_back(resp_data);
            if (error)                  err_obs++;
        end
    end

    always @(posedge clk) begin
        if (rand_wr) begin
            #1;
            if (rand_wr) wr_ready = 1'($urandom_range(0, 1));
        end
    end

    function automatic logic [68:0] all_outs();
        return {cmd_valid, cmd_code, cmd_addr, cmd_len, wr_valid, wr_data, wr_addr,
                resp_valid, resp_data, error};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        rx_data  = 8'($urandom);
        tick(gap);
    endtask

    task automatic send_stream(input logic [7:0] bs[$], input int max_gap);
        foreach (bs[i]) send_byte(bs[i], $urandom_range(0, max_gap));
    endtask

    task automatic clear_obs();
        cmd_obs.delete();
        wr_obs.delete();
        resp_obs.delete();
        err_obs = 0;
    endtask

    // Waits for the FIFO and response register to empty, bounded.
    task automatic drain(input string name);
        int n = 0;
        while ((wr_valid || resp_valid) && n < 300) begin
            tick(1);
            n++;
        end
        checks++;
        if (wr_valid || resp_valid) begin
            errors++;
            $display("FAIL %s_drain: wr_valid=%b resp_valid=%b, required both 0 within 300 cycles",
                     name, wr_valid, resp_valid);
        end
        tick(2);
    endtask

    // Reference: scans a byte stream starting from the idle hunt state.
    task automatic model_packet(input logic [7:0] bs[$]);
        int          i = 0;
        int          n = bs.size();
        int          len;
        int          got;
        logic [7:0]  code;
        logic [15:0] addr;
        while (i < n) begin
            if (bs[i] != 8'hAA) begin
                i++;
                continue;
            end
            i++;
            while (i < n && bs[i] == 8'hAA) i++;
            if (i >= n) break;
            if (bs[i] != 8'h55) begin
                i++;
                continue;
            end
            if (i + 1 >= n) break;
            code = bs[i+1];
            i += 2;
            if (code != 8'h01 && code != 8'h02) begin
                exp_resp.push_back(8'h15);
                exp_err++;
                continue;
            end
            if (i + 3 > n) break;
            addr = {bs[i], bs[i+1]};
            len  = (bs[i+2] == 8'h00) ? 256 : int'(bs[i+2]);
            i += 3;
            exp_cmd.push_back({code, addr, 9'(len)});
            if (code == 8'h01) begin
                exp_resp.push_back(8'h06);
                continue;
            end
            got = 0;
            while (got < len && i < n) begin
                exp_wr.push_back({16'((int'(addr) + got) % 65536), bs[i]});
                got++;
                i++;
            end
            if (got == len) exp_resp.push_back(8'h06);
        end
    endtask

    task automatic test_reset();
        n_reset    = 1'b0;
        rx_ready   = 1'b0;
        rx_data    = 8'h00;
        wr_ready   = 1'b1;
        resp_ready = 1'b1;
        tick(3);
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0", all_outs());
        end
        n_reset = 1'b1;
        tick(2);
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL reset_idle: got %h, required 0", all_outs());
        end
    endtask

    task automatic test_write_basic();
        logic [7:0] pkt[$];
        clear_obs();
        pkt = {8'hAA, 8'h55, 8'h02, 8'h00, 8'h00, 8'h04, 8'hE1, 8'hE2, 8'hE3, 8'hE4};
        send_stream(pkt, 0);
        drain("write_basic");
        checks++;
        if (cmd_obs.size() != 1 || cmd_obs[0] !== {8'h02, 16'h0000, 9'd4}) begin
            errors++;
            $display("FAIL write_cmd: got %0d headers first %h, required 1 header %h",
                     cmd_obs.size(), cmd_obs[0], {8'h02, 16'h0000, 9'd4});
        end
        checks++;
        if (wr_obs.size() != 4) begin
            errors++;
            $display("FAIL write_count: got %0d bytes, required 4", wr_obs.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (wr_obs[k] !== {16'(k), 8'(8'hE1 + k)}) begin
                    errors++;
                    $display("FAIL write_byte%0d: got %h, required %h", k, wr_obs[k], {16'(k), 8'(8'hE1 + k)});
                end
            end
        end
        checks++;
        if (resp_obs.size() != 1 || resp_obs[0] !== 8'h06 || err_obs != 0) begin
            errors++;
            $display("FAIL write_resp: got %0d resp first %h errors %0d, required one 06 and no error",
                     resp_obs.size(), resp_obs[0], err_obs);
        end
    endtask

    task automatic test_read_resync();
        logic [7:0] pkt[$];
        clear_obs();
        pkt = {8'hAA, 8'hAA, 8'h55, 8'h01, 8'h12, 8'h34, 8'h00};
        send_stream(pkt, 1);
        drain("read_resync");
        checks++;
        if (cmd_obs.size() != 1 || cmd_obs[0] !== {8'h01, 16'h1234, 9'd256}) begin
            errors++;
            $display("FAIL read_cmd: got %0d headers first %h, required %h",
                     cmd_obs.size(), cmd_obs[0], {8'h01, 16'h1234, 9'd256});
        end
        checks++;
        if (wr_obs.size() != 0 || resp_obs.size() != 1 || resp_obs[0] !== 8'h06) begin
            errors++;
            $display("FAIL read_resp: got %0d wr bytes, %0d resp first %h, required 0 wr and one 06",
                     wr_obs.size(), resp_obs.size(), resp_obs[0]);
        end
    endtask

    task automatic test_bad_cmd();
        logic [7:0] pkt[$];
        clear_obs();
        pkt = {8'hAA, 8'h55, 8'h07, 8'hAA, 8'h55, 8'h01, 8'h00, 8'h10, 8'h05};
        send_stream(pkt, 0);
        drain("bad_cmd");
        checks++;
        if (err_obs != 1 || resp_obs.size() != 2 || resp_obs[0] !== 8'h15 || resp_obs[1] !== 8'h06) begin
            errors++;
            $display("FAIL bad_cmd_resp: got %0d errors, %0d resp (%h %h), required 1 error, resp 15 06",
                     err_obs, resp_obs.size(), resp_obs[0], resp_obs[1]);
        end
        checks++;
        if (cmd_obs.size() != 1 || cmd_obs[0] !== {8'h01, 16'h0010, 9'd5}) begin
            errors++;
            $display("FAIL bad_cmd_next: got %0d headers first %h, required %h",
                     cmd_obs.size(), cmd_obs[0], {8'h01, 16'h0010, 9'd5});
        end
    endtask

    task automatic test_wrap();
        logic [7:0]  pkt[$];
        logic [23:0] want[3];
        clear_obs();
        want = '{{16'hFFFE, 8'hC1}, {16'hFFFF, 8'hC2}, {16'h0000, 8'hC3}};
        pkt  = {8'hAA, 8'h55, 8'h02, 8'hFF, 8'hFE, 8'h03, 8'hC1, 8'hC2, 8'hC3};
        send_stream(pkt, 2);
        drain("wrap");
        checks++;
        if (wr_obs.size() != 3) begin
            errors++;
            $display("FAIL wrap_count: got %0d bytes, required 3", wr_obs.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (wr_obs[k] !== want[k]) begin
                    errors++;
                    $display("FAIL wrap_byte%0d: got %h, required %h", k, wr_obs[k], want[k]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] pkt[$];
        clear_obs();
        wr_ready = 1'b0;
        pkt = {8'hAA, 8'h55, 8'h02, 8'h00, 8'h40, 8'(FIFO_DEPTH + 1)};
        send_stream(pkt, 0);
        for (int k = 0; k < FIFO_DEPTH; k++) send_byte(8'(8'hD0 + k), 0);
        tick(1);
        checks++;
        if (err_obs != 0 || error !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL overflow_early: got errors=%0d resp_valid=%b after %0d bytes, required none",
                     err_obs, resp_valid, FIFO_DEPTH);
        end
        send_byte(8'(8'hD0 + FIFO_DEPTH), 0);
        tick(3);
        checks++;
        if (err_obs != 1 || resp_obs.size() != 1 || resp_obs[0] !== 8'h15 || wr_valid !== 1'b1) begin
            errors++;
            $display("FAIL overflow_abort: got errors=%0d resp count %0d first %h wr_valid=%b, required 1, one 15, 1",
                     err_obs, resp_obs.size(), resp_obs[0], wr_valid);
        end
        wr_ready = 1'b1;
        drain("overflow");
        checks++;
        if (wr_obs.size() != FIFO_DEPTH) begin
            errors++;
            $display("FAIL overflow_drain: got %0d bytes, required %0d", wr_obs.size(), FIFO_DEPTH);
        end else begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                checks++;
                if (wr_obs[k] !== {16'(16'h0040 + k), 8'(8'hD0 + k)}) begin
                    errors++;
                    $display("FAIL overflow_byte%0d: got %h, required %h", k, wr_obs[k],
                             {16'(16'h0040 + k), 8'(8'hD0 + k)});
                end
            end
        end
    endtask

    task automatic test_resp_hold();
        logic [7:0] pkt[$];
        clear_obs();
        resp_ready = 1'b0;
        pkt = {8'hAA, 8'h55, 8'h01, 8'h00, 8'h00, 8'h01};
        send_stream(pkt, 0);
        tick(10);
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 8'h06) begin
            errors++;
            $display("FAIL resp_hold: got valid=%b data=%h, required 1 06", resp_valid, resp_data);
        end
        pkt = {8'hAA, 8'h55, 8'h33};
        send_stream(pkt, 0);
        tick(3);
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 8'h15) begin
            errors++;
            $display("FAIL resp_overwrite: got valid=%b data=%h, required 1 15", resp_valid, resp_data);
        end
        resp_ready = 1'b1;
        tick(3);
        checks++;
        if (resp_obs.size() != 1 || resp_obs[0] !== 8'h15 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL resp_taken: got %0d resp first %h valid=%b, required one 15 then idle",
                     resp_obs.size(), resp_obs[0], resp_valid);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] pkt[$];
        int         cyc = 0;
        clear_obs();
        pkt = {8'hAA, 8'h55, 8'h02, 8'h12};
        send_stream(pkt, 0);
        while (error !== 1'b1 && cyc < TIMEOUT + 20) begin
            tick(1);
            cyc++;
        end
        checks++;
        if (cyc < TIMEOUT || cyc > TIMEOUT + 2) begin
            errors++;
            $display("FAIL timeout_delay: error after %0d idle cycles, required %0d..%0d",
                     cyc, TIMEOUT, TIMEOUT + 2);
        end
        tick(3);
        checks++;
        if (resp_obs.size() != 1 || resp_obs[0] !== 8'h15 || cmd_obs.size() != 0) begin
            errors++;
            $display("FAIL timeout_resp: got %0d resp first %h, %0d headers, required one 15 and no header",
                     resp_obs.size(), resp_obs[0], cmd_obs.size());
        end
    endtask

    task automatic test_reset_mid_data();
        logic [7:0] pkt[$];
        clear_obs();
        wr_ready   = 1'b0;
        resp_ready = 1'b0;
        pkt = {8'hAA, 8'h55, 8'h09, 8'hAA, 8'h55, 8'h02, 8'h00, 8'h00, 8'h08, 8'h31, 8'h32, 8'h33};
        send_stream(pkt, 0);
        checks++;
        if (wr_valid !== 1'b1 || resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_setup: got wr_valid=%b resp_valid=%b, required 1 1", wr_valid, resp_valid);
        end
        #2 n_reset = 1'b0;
        #1;
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h, required 0", all_outs());
        end
        tick(2);
        n_reset    = 1'b1;
        wr_ready   = 1'b1;
        resp_ready = 1'b1;
        tick(1);
        clear_obs();
        pkt = {8'h44, 8'hAA, 8'h55, 8'h01, 8'hAB, 8'hCD, 8'h02};
        send_stream(pkt, 0);
        drain("midreset");
        checks++;
        if (cmd_obs.size() != 1 || cmd_obs[0] !== {8'h01, 16'hABCD, 9'd2} || wr_obs.size() != 0 ||
            resp_obs.size() != 1 || resp_obs[0] !== 8'h06) begin
            errors++;
            $display("FAIL midreset_after: got %0d headers first %h, %0d wr, %0d resp first %h, required header %h, no wr, one 06",
                     cmd_obs.size(), cmd_obs[0], wr_obs.size(), resp_obs.size(), resp_obs[0],
                     {8'h01, 16'hABCD, 9'd2});
        end
    endtask

    task automatic test_random();
        logic [7:0]  pkt[$];
        logic [7:0]  b;
        logic [15:0] addr;
        int          len;
        rand_wr = 1'b1;
        for (int p = 0; p < 40; p++) begin
            clear_obs();
            exp_cmd.delete();
            exp_wr.delete();
            exp_resp.delete();
            exp_err = 0;
            pkt.delete();
            case ($urandom_range(0, 3))
                0: repeat ($urandom_range(1, 3)) begin
                    b = 8'($urandom);
                    if (b == 8'hAA) b = 8'h00;
                    pkt.push_back(b);
                end
                1: begin
                    b = 8'($urandom);
                    if (b == 8'h01 || b == 8'h02) b = 8'h7F;
                    pkt = {8'hAA, 8'h55, b};
                end
                2: begin
                    pkt.push_back(8'hAA);
                    if ($urandom_range(0, 1) == 1) pkt.push_back(8'hAA);
                    pkt.push_back(8'h55);
                    pkt.push_back(8'h01);
                    repeat (3) pkt.push_back(8'($urandom));
                end
                default: begin
                    len  = $urandom_range(1, 8);
                    addr = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'(16'hFFFA + $urandom_range(0, 5));
                    pkt  = {8'hAA, 8'h55, 8'h02, addr[15:8], addr[7:0], 8'(len)};
                    repeat (len) pkt.push_back(8'($urandom));
                end
            endcase
            model_packet(pkt);
            send_stream(pkt, 2);
            drain("random");
            checks++;
            if (cmd_obs.size() != exp_cmd.size() || wr_obs.size() != exp_wr.size() ||
                resp_obs.size() != exp_resp.size() || err_obs != exp_err) begin
                errors++;
                $display("FAIL random%0d_counts: got cmd/wr/resp/err %0d/%0d/%0d/%0d, required %0d/%0d/%0d/%0d",
                         p, cmd_obs.size(), wr_obs.size(), resp_obs.size(), err_obs,
                         exp_cmd.size(), exp_wr.size(), exp_resp.size(), exp_err);
            end else begin
                foreach (exp_cmd[k]) begin
                    checks++;
                    if (cmd_obs[k] !== exp_cmd[k]) begin
                        errors++;
                        $display("FAIL random%0d_cmd: got %h, required %h", p, cmd_obs[k], exp_cmd[k]);
                    end
                end
                foreach (exp_wr[k]) begin
                    checks++;
                    if (wr_obs[k] !== exp_wr[k]) begin
                        errors++;
                        $display("FAIL random%0d_wr%0d: got %h, required %h", p, k, wr_obs[k], exp_wr[k]);
                    end
                end
                foreach (exp_resp[k]) begin
                    checks++;
                    if (resp_obs[k] !== exp_resp[k]) begin
                        errors++;
                        $display("FAIL random%0d_resp: got %h, required %h", p, resp_obs[k], exp_resp[k]);
                    end
                end
            end
        end
        rand_wr = 1'b0;
        tick(1);
        #1 wr_ready = 1'b1;
        tick(1);
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_resync();
        test_bad_cmd();
        test_wrap();
        test_overflow();
        test_resp_hold();
        test_timeout();
        test_random();
        test_reset_mid_data();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Byte-stream command parser between the host UART receiver and the I2C ROM write engine of the ROM programmer. Hunts for the 0xAA 0x55 sync pair and decodes the command header: command, 16-bit big-endian address and length. Write payload bytes are buffered in a small FIFO and handed downstream with their target addresses. Completion and errors are reported to the host as single ACK/NAK response bytes.

## Interface
Parameters:
- FIFO_DEPTH, 16: payload FIFO entries; power of two, at least 4.
- TIMEOUT, 100000: maximum clk cycles allowed between bytes of one packet.

Ports:
- clk, input, 1: system clock.
- n_reset, input, 1: asynchronous, active-low reset.
- rx_data, input, 8: byte from the UART receiver.
- rx_ready, input, 1: one-cycle strobe; rx_data is valid in that cycle.
- cmd_valid, output, 1: one-cycle strobe; the header is decoded.
- cmd_code, output, 8: command byte.
- cmd_addr, output, 16: start address.
- cmd_len, output, 9: byte count, 1 to 256.
- wr_valid, output, 1: payload byte available (FIFO not empty).
- wr_ready, input, 1: downstream accepts the byte.
- wr_data, output, 8: payload byte.
- wr_addr, output, 16: ROM address of wr_data.
- resp_valid, output, 1: response byte pending.
- resp_ready, input, 1: UART transmitter takes the response.
- resp_data, output, 8: 0x06 (ACK) or 0x15 (NAK).
- error, output, 1: one-cycle strobe on any abort.

## Operation
- States: HUNT_AA, HUNT_55, CMD, ADDR_HI, ADDR_LO, LEN, DATA. Each state advances only on rx_ready.
- HUNT_AA: a byte of 0xAA moves to HUNT_55. Any other byte is ignored.
- HUNT_55:
  - 0x55 moves to CMD.
  - 0xAA stays in HUNT_55 (resync).
  - Any other byte returns to HUNT_AA, with no error.
- CMD:
  - 0x01 (read) and 0x02 (write) are captured and move to ADDR_HI.
  - Any other value aborts.
- ADDR_HI then ADDR_LO capture the address, big-endian.
- LEN: the received byte 0x00 encodes 256; otherwise cmd_len = byte value. cmd_valid pulses for both commands.
  - Read: ACK is queued and the FSM returns to HUNT_AA.
  - Write: the FSM moves to DATA with remaining = cmd_len.
- DATA:
  - Each byte is pushed to the FIFO together with its address, then the address increments. 0xFFFF wraps to 0x0000.
  - On the last byte, ACK is queued and the FSM returns to HUNT_AA.
- Abort (bad command, timeout or overflow):
  - error pulses, NAK is queued and the FSM goes to HUNT_AA.
  - Bytes already in the FIFO remain and drain normally.
- Timeout: a counter clears on every rx_ready. In any state other than HUNT_AA, reaching TIMEOUT aborts the packet.
- Overflow: a DATA byte arriving while the FIFO is full, with no pop in the same cycle, aborts. That byte is dropped.
- Response register:
  - Held until resp_valid & resp_ready.
  - A new response while one is pending overwrites it; the last event wins.

## Timing
- Reset values:
  - FSM in HUNT_AA; FIFO empty.
  - All outputs 0: cmd_valid, cmd_code, cmd_addr, cmd_len, wr_valid, wr_data, wr_addr, resp_valid, resp_data, error.
- cmd_valid asserts in the cycle after the LEN rx_ready. cmd_code, cmd_addr and cmd_len stay stable until the next cmd_valid.
- FIFO:
  - A pushed byte appears on wr_valid/wr_data in the cycle after its rx_ready.
  - A pop on wr_valid & wr_ready takes effect at that clock edge.
  - Push and pop in the same cycle are allowed, including when full.
- resp_valid asserts in the cycle after the completing or aborting event.
- error asserts in the same cycle as the NAK is loaded.
- When n_reset asserts mid-packet, the packet, the FIFO contents and any pending response are lost immediately. No NAK is sent.

## Structure
- Shared package uart_cmd_pkg:
  - FSM state enum.
  - Constants SYNC0 = 0xAA, SYNC1 = 0x55, CMD_READ = 0x01, CMD_WRITE = 0x02, RESP_ACK = 0x06, RESP_NAK = 0x15.
- Sub-module cmd_fifo:
  - Synchronous FIFO, 24 bits wide ({addr, data}), depth FIFO_DEPTH, with full and empty flags.
  - Uses the same clk / n_reset.

## Test plan
- Packet AA 55 02 00 00 04 E1 E2 E3 E4, with wr_ready held high:
  - cmd_valid with cmd 0x02, address 0x0000, length 4.
  - wr outputs (0000,E1) (0001,E2) (0002,E3) (0003,E4).
  - resp 0x06.
- Packet AA AA 55 01 12 34 00:
  - Resync succeeds; cmd_valid with cmd 0x01, address 0x1234, length 256.
  - ACK; no wr_valid.
- Packet AA 55 07: error pulses, resp 0x15, the FSM returns to HUNT_AA, and a following valid packet is accepted.
- Write header AA 55 02 FF FE 03 C1 C2 C3: addresses FFFE, FFFF, 0000 (wrap check).
- wr_ready held low and a write of FIFO_DEPTH+1 bytes:
  - The first 16 bytes are stored.
  - The 17th byte triggers error and NAK.
  - Raising wr_ready drains exactly 16 bytes.
- Overlapping error cases:
  - Stopping after the ADDR_HI byte for TIMEOUT cycles gives error and NAK.
  - In a separate run, n_reset asserted mid-DATA clears all outputs to 0 at once.
